cpu_controller: RTL and testbench

//  Control FSM and instruction decoder that drives the datapath's control inputs.

---
 rtl/cpu_controller_pkg.sv | 32 +++
 rtl/cpu_controller_instr_dec.sv | 26 ++
 rtl/cpu_controller.sv | 159 +++++++++++++++
 tb/tb_cpu_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the SIMPLE RISC controller: FSM state encodings,
// opcode/op field values, mem_cmd codes and one-hot writeback selects.
package cpu_controller_pkg;

   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
      S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_EXEC_S, S_WR_REG,
      S_ADDR, S_LD_ADDR, S_MRD1, S_MRD2, S_GET_RD, S_PASS, S_MWR,
      S_HALT
   } state_t;

   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOVREG = 2'b00;
   localparam logic [1:0] OP_MOVIMM = 2'b10;
   localparam logic [1:0] OP_CMP    = 2'b01;
   localparam logic [1:0] OP_MVN    = 2'b11;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam logic [3:0] VSEL_MDATA = 4'b1000;
   localparam logic [3:0] VSEL_IMM8  = 4'b0100;
   localparam logic [3:0] VSEL_PC    = 4'b0010;
   localparam logic [3:0] VSEL_C     = 4'b0001;

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// Combinational instruction field extraction and immediate sign extension.
module cpu_controller_instr_dec #(
   parameter int RW = 3,
   parameter int DW = 16
) (
   input  logic [DW-1:0] i_ir,
   output logic [2:0]    o_opcode,
   output logic [1:0]    o_op,
   output logic [RW-1:0] o_rn,
   output logic [RW-1:0] o_rd,
   output logic [RW-1:0] o_rm,
   output logic [1:0]    o_sh,
   output logic [DW-1:0] o_sximm8,
   output logic [DW-1:0] o_sximm5
);

   assign o_opcode = i_ir[15:13];
   assign o_op     = i_ir[12:11];
   assign o_rn     = i_ir[8 +: RW];
   assign o_rd     = i_ir[5 +: RW];
   assign o_rm     = i_ir[0 +: RW];
   assign o_sh     = i_ir[4:3];
   assign o_sximm8 = {{(DW-8){i_ir[7]}}, i_ir[7:0]};
   assign o_sximm5 = {{(DW-5){i_ir[4]}}, i_ir[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// SIMPLE RISC control FSM (Moore, one state per cycle) driving the datapath.
// Build option CPU_ILLEGAL_TRAP_EN: undefined encodings halt instead of acting as NOPs.
module cpu_controller
   import cpu_controller_pkg::*;
#(
   parameter int RW = 3,
   parameter int DW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [DW-1:0] i_ir,
   output logic [3:0]    o_vsel,
   output logic [RW-1:0] o_writenum,
   output logic [RW-1:0] o_readnum,
   output logic          o_write,
   output logic          o_loada,
   output logic          o_loadb,
   output logic          o_loadc,
   output logic          o_loads,
   output logic          o_asel,
   output logic          o_bsel,
   output logic [1:0]    o_shift,
   output logic [1:0]    o_aluop,
   output logic [DW-1:0] o_sximm8,
   output logic [DW-1:0] o_sximm5,
   output logic [1:0]    o_mem_cmd,
   output logic          o_addr_sel,
   output logic          o_load_ir,
   output logic          o_load_pc,
   output logic          o_reset_pc,
   output logic          o_load_addr,
   output logic          o_halted
);

`ifdef CPU_ILLEGAL_TRAP_EN
   localparam state_t S_UNDEF = S_HALT;
`else
   localparam state_t S_UNDEF = S_IF1;
`endif

   state_t          r_state, w_next;
   logic [2:0]      w_opcode;
   logic [1:0]      w_op, w_sh;
   logic [RW-1:0]   w_rn, w_rd, w_rm;

   cpu_controller_instr_dec #(.RW(RW), .DW(DW)) u_dec (
      .i_ir     (i_ir),
      .o_opcode (w_opcode),
      .o_op     (w_op),
      .o_rn     (w_rn),
      .o_rd     (w_rd),
      .o_rm     (w_rm),
      .o_sh     (w_sh),
      .o_sximm8 (o_sximm8),
      .o_sximm5 (o_sximm5)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_RST;
      else          r_state <= w_next;
   end

   // Memory ops decode on opcode alone; the op field is don't-care for LDR/STR.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_RST:     w_next = S_IF1;
         S_IF1:     w_next = S_IF2;
         S_IF2:     w_next = S_UPD_PC;
         S_UPD_PC:  w_next = S_DECODE;
         S_DECODE: begin
            w_next = S_UNDEF;
            case (w_opcode)
               OPC_MOV: begin
                  if (w_op == OP_MOVIMM)      w_next = S_WR_IMM;
                  else if (w_op == OP_MOVREG) w_next = S_GET_B;
               end
               OPC_ALU:          w_next = (w_op == OP_MVN) ? S_GET_B : S_GET_A;
               OPC_LDR, OPC_STR: w_next = S_GET_A;
               OPC_HALT:         w_next = S_HALT;
               default:          w_next = S_UNDEF;
            endcase
         end
         S_GET_A:   w_next = (w_opcode == OPC_ALU) ? S_GET_B : S_ADDR;
         S_GET_B:   w_next = (w_opcode == OPC_ALU && w_op == OP_CMP) ? S_EXEC_S : S_EXEC;
         S_EXEC:    w_next = S_WR_REG;
         S_EXEC_S:  w_next = S_IF1;
         S_WR_REG:  w_next = S_IF1;
         S_WR_IMM:  w_next = S_IF1;
         S_ADDR:    w_next = S_LD_ADDR;
         S_LD_ADDR: w_next = (w_opcode == OPC_LDR) ? S_MRD1 : S_GET_RD;
         S_MRD1:    w_next = S_MRD2;
         S_MRD2:    w_next = S_IF1;
         S_GET_RD:  w_next = S_PASS;
         S_PASS:    w_next = S_MWR;
         S_MWR:     w_next = S_IF1;
         S_HALT:    w_next = S_HALT;
         default:   w_next = S_RST;
      endcase
   end

   // All control outputs are forced low while reset is asserted.
   always_comb begin
      o_vsel      = 4'b0000;
      o_writenum  = '0;
      o_readnum   = '0;
      o_write     = 1'b0;
      o_loada     = 1'b0;
      o_loadb     = 1'b0;
      o_loadc     = 1'b0;
      o_loads     = 1'b0;
      o_asel      = 1'b0;
      o_bsel      = 1'b0;
      o_shift     = 2'b00;
      o_aluop     = 2'b00;
      o_mem_cmd   = MNONE;
      o_addr_sel  = 1'b0;
      o_load_ir   = 1'b0;
      o_load_pc   = 1'b0;
      o_reset_pc  = 1'b0;
      o_load_addr = 1'b0;
      o_halted    = 1'b0;
      if (i_rst_n) begin
         unique case (r_state)
            S_RST:     begin o_reset_pc = 1'b1; o_load_pc = 1'b1; end
            S_IF1:     begin o_addr_sel = 1'b1; o_mem_cmd = MREAD; end
            S_IF2:     begin o_addr_sel = 1'b1; o_mem_cmd = MREAD; o_load_ir = 1'b1; end
            S_UPD_PC:  o_load_pc = 1'b1;
            S_DECODE:  ;
            S_WR_IMM:  begin o_vsel = VSEL_IMM8; o_writenum = w_rn; o_write = 1'b1; end
            S_GET_A:   begin o_readnum = w_rn; o_loada = 1'b1; end
            S_GET_B:   begin o_readnum = w_rm; o_loadb = 1'b1; end
            S_EXEC: begin
               o_loadc = 1'b1;
               o_shift = w_sh;
               if (w_opcode == OPC_MOV) o_asel  = 1'b1;
               else                     o_aluop = w_op;
            end
            S_EXEC_S:  begin o_loads = 1'b1; o_aluop = w_op; o_shift = w_sh; end
            S_WR_REG:  begin o_vsel = VSEL_C; o_writenum = w_rd; o_write = 1'b1; end
            S_ADDR:    begin o_bsel = 1'b1; o_loadc = 1'b1; end
            S_LD_ADDR: o_load_addr = 1'b1;
            S_MRD1:    o_mem_cmd = MREAD;
            S_MRD2: begin
               o_mem_cmd  = MREAD;
               o_vsel     = VSEL_MDATA;
               o_writenum = w_rd;
               o_write    = 1'b1;
            end
            S_GET_RD:  begin o_readnum = w_rd; o_loadb = 1'b1; end
            S_PASS:    begin o_asel = 1'b1; o_loadc = 1'b1; end
            S_MWR:     o_mem_cmd = MWRITE;
            S_HALT:    o_halted = 1'b1;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus queues per-cycle expected control
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_cpu_controller;

   typedef struct packed {
      logic [3:0]  vsel;
      logic [2:0]  writenum;
      logic [2:0]  readnum;
      logic        write;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic        bsel;
      logic [1:0]  shift;
      logic [1:0]  aluop;
      logic [15:0] sximm8;
      logic [15:0] sximm5;
      logic [1:0]  mem_cmd;
      logic        addr_sel;
      logic        load_ir;
      logic        load_pc;
      logic        reset_pc;
      logic        load_addr;
      logic        halted;
   } ctl_t;

   typedef struct {
      ctl_t  c;
      string tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] ir = 16'h0000;
   logic [3:0]  vsel;
   logic [2:0]  writenum, readnum;
   logic        write, loada, loadb, loadc, loads, asel, bsel;
   logic [1:0]  shift, aluop, mem_cmd;
   logic [15:0] sximm8, sximm5;
   logic        addr_sel, load_ir, load_pc, reset_pc, load_addr, halted;

   exp_t        exp_q[$];
   logic [15:0] cur8 = 16'h0000;
   logic [15:0] cur5 = 16'h0000;
   int          checks = 0;
   int          errors = 0;

   cpu_controller dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ir        (ir),
      .o_vsel      (vsel),
      .o_writenum  (writenum),
      .o_readnum   (readnum),
      .o_write     (write),
      .o_loada     (loada),
      .o_loadb     (loadb),
      .o_loadc     (loadc),
      .o_loads     (loads),
      .o_asel      (asel),
      .o_bsel      (bsel),
      .o_shift     (shift),
      .o_aluop     (aluop),
      .o_sximm8    (sximm8),
      .o_sximm5    (sximm5),
      .o_mem_cmd   (mem_cmd),
      .o_addr_sel  (addr_sel),
      .o_load_ir   (load_ir),
      .o_load_pc   (load_pc),
      .o_reset_pc  (reset_pc),
      .o_load_addr (load_addr),
      .o_halted    (halted)
   );

   always #5 clk = ~clk;

   // Monitor: one expected vector is consumed per cycle at the falling edge.
   always @(negedge clk) begin
      exp_t x;
      ctl_t a;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         a.vsel = vsel;       a.writenum = writenum; a.readnum = readnum;
         a.write = write;     a.loada = loada;       a.loadb = loadb;
         a.loadc = loadc;     a.loads = loads;       a.asel = asel;
         a.bsel = bsel;       a.shift = shift;       a.aluop = aluop;
         a.sximm8 = sximm8;   a.sximm5 = sximm5;     a.mem_cmd = mem_cmd;
         a.addr_sel = addr_sel; a.load_ir = load_ir; a.load_pc = load_pc;
         a.reset_pc = reset_pc; a.load_addr = load_addr; a.halted = halted;
         checks++;
         if (a !== x.c) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", x.tag, a, x.c);
         end
      end
   end

   function automatic ctl_t z();
      ctl_t e;
      e = '0;
      e.sximm8 = cur8;
      e.sximm5 = cur5;
      return e;
   endfunction

   task automatic put(input ctl_t e, input string tag);
      exp_t x;
      x.c = e;
      x.tag = tag;
      exp_q.push_back(x);
   endtask

   task automatic run();
      int n;
      n = exp_q.size();
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Loads the instruction and queues the common IF1/IF2/UPD_PC/DECODE cycles.
   task automatic start(input logic [15:0] v, input logic [15:0] x8, input logic [15:0] x5,
                        input string nm);
      ctl_t e;
      ir = v; cur8 = x8; cur5 = x5;
      e = z(); e.addr_sel = 1'b1; e.mem_cmd = 2'b01; put(e, {nm, " IF1"});
      e.load_ir = 1'b1;                              put(e, {nm, " IF2"});
      e = z(); e.load_pc = 1'b1;                     put(e, {nm, " UPD_PC"});
      put(z(), {nm, " DECODE"});
   endtask

   initial begin
      ctl_t e;
      @(posedge clk); #1;
      put(z(), "reset low 0");
      put(z(), "reset low 1");
      run();
      rst_n = 1'b1;
      e = z(); e.reset_pc = 1'b1; e.load_pc = 1'b1; put(e, "RST");
      run();

      // MOV R1,#5
      start(16'hD105, 16'h0005, 16'h0005, "MOVI");
      e = z(); e.vsel = 4'b0100; e.writenum = 3'd1; e.write = 1'b1; put(e, "MOVI WR_IMM");
      run();

      // ADD R5,R0,R2 LSL1
      start(16'hA0AA, 16'hFFAA, 16'h000A, "ADD");
      e = z(); e.readnum = 3'd0; e.loada = 1'b1; put(e, "ADD GET_A");
      e = z(); e.readnum = 3'd2; e.loadb = 1'b1; put(e, "ADD GET_B");
      e = z(); e.loadc = 1'b1; e.shift = 2'b01; e.aluop = 2'b00; put(e, "ADD EXEC");
      e = z(); e.vsel = 4'b0001; e.writenum = 3'd5; e.write = 1'b1; put(e, "ADD WR_REG");
      run();

      // CMP R1,R2 LSL1
      start(16'hA90A, 16'h000A, 16'h000A, "CMP");
      e = z(); e.readnum = 3'd1; e.loada = 1'b1; put(e, "CMP GET_A");
      e = z(); e.readnum = 3'd2; e.loadb = 1'b1; put(e, "CMP GET_B");
      e = z(); e.loads = 1'b1; e.aluop = 2'b01; e.shift = 2'b01; put(e, "CMP EXEC_S");
      run();

      // LDR R2,[R2,#-1]
      start(16'h6A5F, 16'h005F, 16'hFFFF, "LDR");
      e = z(); e.readnum = 3'd2; e.loada = 1'b1; put(e, "LDR GET_A");
      e = z(); e.bsel = 1'b1; e.loadc = 1'b1;    put(e, "LDR ADDR");
      e = z(); e.load_addr = 1'b1;               put(e, "LDR LD_ADDR");
      e = z(); e.mem_cmd = 2'b01;                put(e, "LDR MRD1");
      e.vsel = 4'b1000; e.writenum = 3'd2; e.write = 1'b1; put(e, "LDR MRD2");
      run();

      // STR R3,[R1]
      start(16'h8160, 16'h0060, 16'h0000, "STR");
      e = z(); e.readnum = 3'd1; e.loada = 1'b1; put(e, "STR GET_A");
      e = z(); e.bsel = 1'b1; e.loadc = 1'b1;    put(e, "STR ADDR");
      e = z(); e.load_addr = 1'b1;               put(e, "STR LD_ADDR");
      e = z(); e.readnum = 3'd3; e.loadb = 1'b1; put(e, "STR GET_RD");
      e = z(); e.asel = 1'b1; e.loadc = 1'b1;    put(e, "STR PASS");
      e = z(); e.mem_cmd = 2'b10;                put(e, "STR MWR");
      run();

      // MOV R3,R4
      start(16'hC064, 16'h0064, 16'h0004, "MOVR");
      e = z(); e.readnum = 3'd4; e.loadb = 1'b1; put(e, "MOVR GET_B");
      e = z(); e.loadc = 1'b1; e.asel = 1'b1;    put(e, "MOVR EXEC");
      e = z(); e.vsel = 4'b0001; e.writenum = 3'd3; e.write = 1'b1; put(e, "MOVR WR_REG");
      run();

      // MVN R7,R1 LSR
      start(16'hB8F1, 16'hFFF1, 16'hFFF1, "MVN");
      e = z(); e.readnum = 3'd1; e.loadb = 1'b1; put(e, "MVN GET_B");
      e = z(); e.loadc = 1'b1; e.aluop = 2'b11; e.shift = 2'b10; put(e, "MVN EXEC");
      e = z(); e.vsel = 4'b0001; e.writenum = 3'd7; e.write = 1'b1; put(e, "MVN WR_REG");
      run();

      // AND R6,R3,R5
      start(16'hB3C5, 16'hFFC5, 16'h0005, "AND");
      e = z(); e.readnum = 3'd3; e.loada = 1'b1; put(e, "AND GET_A");
      e = z(); e.readnum = 3'd5; e.loadb = 1'b1; put(e, "AND GET_B");
      e = z(); e.loadc = 1'b1; e.aluop = 2'b10;  put(e, "AND EXEC");
      e = z(); e.vsel = 4'b0001; e.writenum = 3'd6; e.write = 1'b1; put(e, "AND WR_REG");
      run();

      // Undefined 110/01 falls straight back to IF1 in the default build
      start(16'hC800, 16'h0000, 16'h0000, "UNDEF");
      run();

      // ADD interrupted by reset during GET_B
      start(16'hA0AA, 16'hFFAA, 16'h000A, "ADDRST");
      e = z(); e.readnum = 3'd0; e.loada = 1'b1; put(e, "ADDRST GET_A");
      run();
      rst_n = 1'b0;
      put(z(), "ADDRST reset low");
      run();
      rst_n = 1'b1;
      e = z(); e.reset_pc = 1'b1; e.load_pc = 1'b1; put(e, "ADDRST RST");
      run();

      // HALT holds
      start(16'hE000, 16'h0000, 16'h0000, "HALT");
      for (int i = 0; i < 4; i++) begin
         e = z(); e.halted = 1'b1; put(e, "HALT hold");
      end
      run();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: actual=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
